// File: rtl/arduino_gpu_pkg.sv
// rtl/arduino_gpu_pkg.sv - shared constants, command type and helpers for the Arduino command receiver
package arduino_gpu_pkg;

    localparam logic [5:0]  FB_W    = 6'd40;
    localparam logic [4:0]  FB_H    = 5'd30;
    localparam logic [10:0] FB_SIZE = 11'd1200;

    localparam logic OP_SET  = 1'b0;
    localparam logic OP_FILL = 1'b1;

    typedef enum logic [1:0] {
        S_B0,
        S_B1,
        S_B2
    } asm_state_t;

    typedef struct packed {
        logic       op;
        logic [5:0] x;
        logic [4:0] y;
        logic [1:0] color;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Linear frame address y*40 + x built from shifts (y*32 + y*8 + x)
    function automatic logic [10:0] pix_addr(input logic [5:0] x, input logic [4:0] y);
        return {1'b0, y, 5'b0} + {3'b0, y, 3'b0} + {5'b0, x};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command queue with occupancy count
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             s_tdata,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    output logic [WIDTH-1:0]             m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign s_tready = (count != CW'(DEPTH));
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/arduino_cmd_rx.sv
// rtl/arduino_cmd_rx.sv - Arduino byte-bus command receiver driving frame memory; ARDUINO_CMD_FILL_EN adds the fill engine
module arduino_cmd_rx
    import arduino_gpu_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  bus_data,
    input  logic        bus_strobe,
    input  logic        active,
    output logic        busy,
    output logic        err,
    output logic [10:0] mem_addr,
    output logic [1:0]  mem_data,
    output logic        mem_we
);

    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   byte_rdy;

    asm_state_t state_q;
    asm_state_t state_d;

    logic       op_q;
    logic [5:0] x_q;
    logic [4:0] y_q;

    logic load_b0;
    logic load_y;
    logic complete;
    logic bad_lead;
    logic cmd_ok;
    logic err_set;

    cmd_t          push_cmd;
    cmd_t          head;
    logic          fifo_ready;
    logic          fifo_valid;
    logic          push;
    logic          pop;
    logic          pop_ready;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;

    // Strobe synchronizer plus one extra flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus_strobe};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign byte_rdy = sync_q[SYNC_STAGES-1] & ~sync_prev;

    // Assembler state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_B0;
        end else begin
            state_q <= state_d;
        end
    end

    // Assembler next state: a lead byte always restarts at the byte1 wait
    always_comb begin
        state_d = state_q;
        if (byte_rdy) begin
            if (bus_data[7]) begin
                state_d = S_B1;
            end else begin
                case (state_q)
                    S_B1:    state_d = S_B2;
                    S_B2:    state_d = S_B0;
                    default: state_d = S_B0;
                endcase
            end
        end
    end

    // Assembler decoded actions for the captured byte
    always_comb begin
        load_b0  = 1'b0;
        load_y   = 1'b0;
        complete = 1'b0;
        bad_lead = 1'b0;
        if (byte_rdy) begin
            if (bus_data[7]) begin
                load_b0 = 1'b1;
            end else begin
                case (state_q)
                    S_B1:    load_y   = 1'b1;
                    S_B2:    complete = 1'b1;
                    default: bad_lead = 1'b1;
                endcase
            end
        end
    end

    // Partial command holding registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q <= OP_SET;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            if (load_b0) begin
                op_q <= bus_data[6];
                x_q  <= bus_data[5:0];
            end
            if (load_y) begin
                y_q <= bus_data[4:0];
            end
        end
    end

`ifdef ARDUINO_CMD_FILL_EN
    assign cmd_ok = (op_q == OP_FILL) ? 1'b1 : ((x_q < FB_W) && (y_q < FB_H));
`else
    assign cmd_ok = (op_q == OP_SET) && (x_q < FB_W) && (y_q < FB_H);
`endif

    assign push_cmd = '{op: op_q, x: x_q, y: y_q, color: bus_data[1:0]};
    assign push     = complete & cmd_ok & fifo_ready;
    assign err_set  = bad_lead | (complete & ~cmd_ok) | (complete & cmd_ok & ~fifo_ready);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (push_cmd),
        .s_tvalid (complete & cmd_ok),
        .s_tready (fifo_ready),
        .m_tdata  (head),
        .m_tvalid (fifo_valid),
        .m_tready (pop_ready),
        .count    (fifo_count)
    );

`ifdef ARDUINO_CMD_FILL_EN
    logic        fill_run;
    logic [10:0] fill_addr;
    logic [1:0]  fill_color;

    assign pop_ready = ~active & ~fill_run;
`else
    logic unused_head_op;

    assign unused_head_op = head.op;
    assign pop_ready      = ~active;
`endif

    assign pop        = fifo_valid & pop_ready;
    assign count_next = fifo_count + CW'(push) - CW'(pop);

    // Flow-control and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            err  <= 1'b0;
        end else begin
            busy <= (count_next == CW'(FIFO_DEPTH));
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Frame-memory write port: pops issue a write immediately, fills stream one address per idle cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
`ifdef ARDUINO_CMD_FILL_EN
            fill_run   <= 1'b0;
            fill_addr  <= '0;
            fill_color <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (pop) begin
                mem_we   <= 1'b1;
                mem_data <= head.color;
`ifdef ARDUINO_CMD_FILL_EN
                if (head.op == OP_FILL) begin
                    mem_addr   <= '0;
                    fill_run   <= 1'b1;
                    fill_addr  <= 11'd1;
                    fill_color <= head.color;
                end else begin
                    mem_addr <= pix_addr(head.x, head.y);
                end
            end else if (fill_run && !active) begin
                mem_we   <= 1'b1;
                mem_addr <= fill_addr;
                mem_data <= fill_color;
                if (fill_addr == FB_SIZE - 11'd1) begin
                    fill_run <= 1'b0;
                end else begin
                    fill_addr <= fill_addr + 11'd1;
                end
`else
                mem_addr <= pix_addr(head.x, head.y);
`endif
            end
        end
    end

endmodule

// File: tb/tb_arduino_cmd_rx.sv
// tb/tb_arduino_cmd_rx.sv - randomized self-checking bench with behavioural model for arduino_cmd_rx
module tb_arduino_cmd_rx;

    localparam int DEPTH = 4;
    localparam int S     = 2;
`ifdef ARDUINO_CMD_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  bus_data = 8'h00;
    logic        bus_strobe = 1'b0;
    logic        active = 1'b0;
    logic        busy;
    logic        err;
    logic [10:0] mem_addr;
    logic [1:0]  mem_data;
    logic        mem_we;

    always #5 clk = ~clk;

    arduino_cmd_rx #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_data   (bus_data),
        .bus_strobe (bus_strobe),
        .active     (active),
        .busy       (busy),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we)
    );

    typedef struct {
        int op;
        int x;
        int y;
        int color;
    } mcmd_t;

    mcmd_t      mq[$];
    logic [7:0] part[$];
    int         hist[0:S];
    int         fill_next = -1;
    int         fill_col = 0;
    bit         m_we = 0;
    bit         m_busy = 0;
    bit         m_err = 0;
    int         m_addr = 0;
    int         m_data = 0;
    bit         m_valid = 0;
    bit         act_edge = 0;

    int wlog[$];
    int viol = 0;
    int pass_cnt = 0;
    int tot_cnt = 0;
    bit rand_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural model: bytes seen after S strobe-sample delay, queue of whole commands, fill as a counter
    always @(posedge clk) begin : model_step
        int         pre;
        bit         do_pop;
        bit         rise;
        bit         ok;
        mcmd_t      c;
        logic [7:0] b;
        act_edge = active;
        if (!rst_n) begin
            mq.delete();
            part.delete();
            for (int k = 0; k <= S; k++) hist[k] = 0;
            fill_next = -1;
            m_we = 0; m_addr = 0; m_data = 0; m_busy = 0; m_err = 0;
            m_valid = 1;
        end else begin
            rise = (hist[S-1] != 0) && (hist[S] == 0);
            for (int k = S; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = int'(bus_strobe);
            pre    = mq.size();
            do_pop = !active && pre > 0 && fill_next < 0;
            m_we   = 0;
            if (fill_next >= 0 && !active) begin
                m_we = 1; m_addr = fill_next; m_data = fill_col;
                fill_next = (fill_next == 1199) ? -1 : fill_next + 1;
            end
            if (do_pop) begin
                c = mq.pop_front();
                m_we = 1; m_data = c.color;
                if (c.op != 0) begin
                    m_addr = 0; fill_next = 1; fill_col = c.color;
                end else begin
                    m_addr = c.y * 40 + c.x;
                end
            end
            if (rise) begin
                b = bus_data;
                if (b[7]) begin
                    part.delete();
                    part.push_back(b);
                end else if (part.size() == 0) begin
                    m_err = 1;
                end else begin
                    part.push_back(b);
                    if (part.size() == 3) begin
                        c.op = int'(part[0][6]); c.x = int'(part[0][5:0]);
                        c.y = int'(part[1][4:0]); c.color = int'(part[2][1:0]);
                        ok = (c.op != 0) ? FILL_EN : (c.x < 40 && c.y < 30);
                        if (!ok) m_err = 1;
                        else if (pre == DEPTH) m_err = 1;
                        else mq.push_back(c);
                        part.delete();
                    end
                end
            end
            m_busy = (mq.size() == DEPTH);
        end
    end

    // Per-cycle comparison against the model, plus write log for directed checks
    always @(negedge clk) begin
        if (m_valid) begin
            chk("mem_we", int'(mem_we), int'(m_we));
            chk("busy", int'(busy), int'(m_busy));
            chk("err", int'(err), int'(m_err));
            if (m_we) begin
                chk("mem_addr", int'(mem_addr), m_addr);
                chk("mem_data", int'(mem_data), m_data);
            end
        end
        if (mem_we) begin
            wlog.push_back(int'(mem_addr) * 4 + int'(mem_data));
            if (act_edge) viol++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input int h, input int l);
        bus_data   = b;
        bus_strobe = 1'b1;
        tick(h);
        bus_strobe = 1'b0;
        tick(l);
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 2, 3);
        send_byte(b1, 2, 3);
        send_byte(b2, 2, 3);
    endtask

    task automatic send_rand(input logic [7:0] b);
        send_byte(b, $urandom_range(1, 2), $urandom_range(2, 3));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((mq.size() > 0 || fill_next >= 0) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) chk("idle_timeout", 0, 1);
        tick(3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    function automatic int log_at(input int i);
        return (i < wlog.size()) ? wlog[i] : -1;
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        tick(3);
        chk("reset_we", int'(mem_we), 0);
        chk("reset_addr", int'(mem_addr), 0);
        chk("reset_data", int'(mem_data), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_err", int'(err), 0);
        rst_n = 1'b1;
        tick(2);

        // Single set-pixel x=5 y=3 color=2
        wlog.delete();
        send3(8'h85, 8'h03, 8'h02);
        wait_idle(100);
        chk("t035_count", wlog.size(), 1);
        chk("t035_word", log_at(0), 125 * 4 + 2);
        chk("t035_err", int'(err), 0);

        // Resync: partial command abandoned by a new lead byte
        do_reset();
        wlog.delete();
        send_byte(8'h85, 2, 3);
        send_byte(8'h03, 2, 3);
        send3(8'h8A, 8'h01, 8'h01);
        wait_idle(100);
        chk("t036_count", wlog.size(), 1);
        chk("t036_word", log_at(0), 50 * 4 + 1);
        chk("t036_err", int'(err), 0);

        // Out-of-range x, then the far corner
        wlog.delete();
        send3(8'hA8, 8'h00, 8'h01);
        wait_idle(100);
        chk("t039_drop_count", wlog.size(), 0);
        chk("t039_err", int'(err), 1);
        send3(8'hA7, 8'h1D, 8'h03);
        wait_idle(100);
        chk("t039_corner", log_at(0), 1199 * 4 + 3);

        // Queue overflow during active video
        do_reset();
        active = 1'b1;
        wlog.delete();
        for (int i = 0; i < 4; i++) send3(8'h80 | 8'(i + 1), 8'(i), 8'(i));
        chk("t037_busy4", int'(busy), 1);
        chk("t037_err4", int'(err), 0);
        send3(8'h8F, 8'h02, 8'h01);
        chk("t037_err5", int'(err), 1);
        tick(20);
        chk("t037_quiet", wlog.size(), 0);
        active = 1'b0;
        wait_idle(100);
        chk("t037_count", wlog.size(), 4);
        chk("t037_last", log_at(3), (3 * 40 + 4) * 4 + 3);
        chk("t037_viol", viol, 0);

        // Fill command: streamed with pauses, or rejected when not built in
        do_reset();
        wlog.delete();
        send3(8'hC0, 8'h00, 8'h03);
        if (FILL_EN) begin
            for (int i = 0; i < 8; i++) begin
                tick(100);
                active = ~active;
            end
            active = 1'b0;
            wait_idle(3000);
            bad = 0;
            for (int i = 0; i < wlog.size(); i++) if (wlog[i] != i * 4 + 3) bad++;
            chk("fill_count", wlog.size(), 1200);
            chk("fill_order", bad, 0);
            chk("fill_viol", viol, 0);
            chk("fill_err", int'(err), 0);
        end else begin
            wait_idle(100);
            chk("nofill_count", wlog.size(), 0);
            chk("nofill_err", int'(err), 1);
        end

        // Reset in the middle of outstanding work
        do_reset();
        if (FILL_EN) begin
            send3(8'hC0, 8'h00, 8'h01);
            tick(100);
        end else begin
            active = 1'b1;
            send3(8'h81, 8'h01, 8'h01);
            send3(8'h82, 8'h02, 8'h02);
        end
        rst_n = 1'b0;
        tick(1);
        chk("t040_we", int'(mem_we), 0);
        chk("t040_busy", int'(busy), 0);
        chk("t040_err", int'(err), 0);
        rst_n  = 1'b1;
        active = 1'b0;
        wlog.delete();
        tick(FILL_EN ? 1400 : 60);
        chk("t040_no_resume", wlog.size(), 0);

        // Randomized traffic with random active video
        do_reset();
        fork
            begin
                while (!rand_done) begin
                    tick(1);
                    if ($urandom_range(0, 29) == 0) active = ~active;
                end
            end
        join_none
        for (int i = 0; i < 80; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 7 && $urandom_range(0, 3) != 0) kind = 0;
            case (kind)
                6: begin
                    send_rand(8'h80 | 8'($urandom_range(40, 63)));
                    send_rand(8'($urandom_range(0, 31)));
                    send_rand(8'($urandom_range(0, 3)));
                end
                7: begin
                    send_rand(8'hC0 | 8'($urandom_range(0, 63)));
                    send_rand(8'($urandom_range(0, 127)));
                    send_rand(8'($urandom_range(0, 127)));
                end
                8: send_rand(8'($urandom_range(0, 127)));
                9: begin
                    send_rand(8'h80 | 8'($urandom_range(0, 39)));
                    send_rand(8'h80 | 8'($urandom_range(0, 39)));
                    send_rand(8'($urandom_range(0, 29)));
                    send_rand(8'($urandom_range(0, 3)));
                end
                default: begin
                    send_rand(8'h80 | 8'($urandom_range(0, 39)));
                    send_rand(8'($urandom_range(0, 29)) | 8'($urandom_range(0, 3) << 5));
                    send_rand(8'($urandom_range(0, 3)) | 8'($urandom_range(0, 31) << 2));
                end
            endcase
        end
        rand_done = 1'b1;
        tick(2);
        active = 1'b0;
        wait_idle(10000);
        chk("rand_viol", viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
